pll_cfg_ctrl: RTL

Sequencer for the core clock PLL. Owns PLL reset and lock qualification, and generates the core-wide `sys_rst` from a filtered lock. On request, it switches the PLL between two output-frequency profiles by writing counter words through the Avalon-MM port of the PLL reconfiguration block, then holds the core in reset until lock is re-qualified. It runs on the 50 MHz PLL reference clock.

---
 rtl/pll_cfg_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: core clock PLL sequencer.
// Pulses the PLL reset and qualifies lock through a synchronizer and a stability
// counter, deriving the core reset from the filtered lock. On request it rewrites
// the PLL counters through the reconfiguration block's Avalon-MM port, then waits
// for the lock to be re-qualified before releasing the core again.
module pll_cfg_ctrl #(
  parameter int          RST_HOLD     = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 65535,
  parameter logic [17:0] P0_N         = 18'h10000,
  parameter logic [17:0] P0_M         = 18'h00606,
  parameter logic [17:0] P0_C0        = 18'h00404,
  parameter logic [17:0] P0_C1        = 18'h00404,
  parameter logic [17:0] P1_N         = 18'h10000,
  parameter logic [17:0] P1_M         = 18'h00707,
  parameter logic [17:0] P1_C0        = 18'h00505,
  parameter logic [17:0] P1_C1        = 18'h00505
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        sys_rst,
  input  logic        cfg_req,
  input  logic        prof_sel,
  output logic        cfg_busy,
  output logic        cfg_err,
  output logic        active_prof,
  output logic [5:0]  rc_address,
  output logic        rc_write,
  output logic [31:0] rc_writedata,
  input  logic        rc_waitrequest
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    PRST,
    LWAIT,
    RUN,
    WMODE,
    WN,
    WM,
    WC0,
    WC1,
    WSTART
  } state_t;

  state_t             state_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [STAB_W-1:0]  stab_q;
  logic [TO_W-1:0]    to_q;
  logic [1:0]         sync_q;
  logic               prof_q;
  logic               pll_rst_q;
  logic               sys_rst_q;
  logic               busy_q;
  logic               err_q;
  logic               active_q;
  logic               rc_write_q;
  logic [5:0]         rc_addr_q;
  logic [31:0]        rc_data_q;
  logic               lock_s;

  assign lock_s = sync_q[1];

  // Write state that follows an accepted write in state s.
  function automatic state_t next_write(input state_t s);
    case (s)
      WMODE:   next_write = WN;
      WN:      next_write = WM;
      WM:      next_write = WC0;
      WC0:     next_write = WC1;
      default: next_write = WSTART;
    endcase
  endfunction

  // {address, writedata} presented on the reconfig port while in write state s
  // for profile p. C0/C1 share address 5; bits 22:18 select the counter.
  function automatic logic [37:0] beat(input state_t s, input logic p);
    logic [17:0] n;
    logic [17:0] m;
    logic [17:0] c0;
    logic [17:0] c1;
    n  = p ? P1_N  : P0_N;
    m  = p ? P1_M  : P0_M;
    c0 = p ? P1_C0 : P0_C0;
    c1 = p ? P1_C1 : P0_C1;
    case (s)
      WN:      beat = {6'd3, 14'd0, n};
      WM:      beat = {6'd4, 14'd0, m};
      WC0:     beat = {6'd5, 9'd0, 5'd0, c0};
      WC1:     beat = {6'd5, 9'd0, 5'd1, c1};
      WSTART:  beat = {6'd2, 32'd1};
      default: beat = {6'd0, 32'd0};
    endcase
  endfunction

  // Lock synchronizer; held clear while the PLL is in reset because its locked
  // output means nothing then, so every qualification starts from a fresh sync.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else if (pll_rst_q) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= PRST;
      hold_q     <= '0;
      stab_q     <= '0;
      to_q       <= '0;
      prof_q     <= 1'b0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
      rc_write_q <= 1'b0;
      rc_addr_q  <= '0;
      rc_data_q  <= '0;
    end else begin
      case (state_q)
        PRST: begin
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_q   <= LWAIT;
            pll_rst_q <= 1'b0;
            hold_q    <= '0;
            stab_q    <= '0;
            to_q      <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        LWAIT: begin
          if (stab_q == STAB_MAX) begin
            state_q   <= RUN;
            sys_rst_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (to_q == TO_MAX) begin
            // Lock never qualified: flag it and retry with a fresh PLL reset.
            state_q   <= PRST;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            hold_q    <= '0;
          end else begin
            if (!lock_s) begin
              stab_q <= '0;
            end else if (stab_q != STAB_MAX) begin
              stab_q <= stab_q + 1'b1;
            end
            if (to_q != TO_MAX) begin
              to_q <= to_q + 1'b1;
            end
          end
        end

        RUN: begin
          // Lock loss takes priority over a same-cycle profile request.
          if (!lock_s) begin
            state_q   <= PRST;
            sys_rst_q <= 1'b1;
            pll_rst_q <= 1'b1;
            hold_q    <= '0;
          end else if (cfg_req && (prof_sel != active_q)) begin
            state_q    <= WMODE;
            prof_q     <= prof_sel;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            sys_rst_q  <= 1'b1;
            rc_write_q <= 1'b1;
            {rc_addr_q, rc_data_q} <= beat(WMODE, prof_sel);
          end
        end

        WMODE, WN, WM, WC0, WC1: begin
          if (!rc_waitrequest) begin
            state_q <= next_write(state_q);
            {rc_addr_q, rc_data_q} <= beat(next_write(state_q), prof_q);
          end
        end

        WSTART: begin
          if (!rc_waitrequest) begin
            state_q    <= LWAIT;
            active_q   <= prof_q;
            rc_write_q <= 1'b0;
            rc_addr_q  <= '0;
            rc_data_q  <= '0;
            stab_q     <= '0;
            to_q       <= '0;
          end
        end

        default: begin
          state_q   <= PRST;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          hold_q    <= '0;
        end
      endcase
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign cfg_busy     = busy_q;
  assign cfg_err      = err_q;
  assign active_prof  = active_q;
  assign rc_write     = rc_write_q;
  assign rc_address   = rc_addr_q;
  assign rc_writedata = rc_data_q;

endmodule
